// File: rtl/bayer_frame_sequencer.sv
// Frame sequencer feeding a Bayer demosaic datapath: a vsync strobe, then lines of
// handshaked pixels separated by horizontal blanking, then a pipeline drain and a done pulse.
//   state  | meaning
//   IDLE   | waiting for start; line_cnt keeps the last frame's final line
//   VSYNC  | frame_vsync high for VSYNC_LEN cycles
//   ACTIVE | accepting pixels of the current line
//   HBLANK | HBLANK_LEN idle cycles between lines
//   FLUSH  | PIPE_LAT drain cycles, then frame_done
module bayer_frame_sequencer #(
  parameter int DISP_WIDTH = 402,
  parameter int DISP_HIGHT = 402,
  parameter int HBLANK_LEN = 16,
  parameter int VSYNC_LEN  = 4,
  parameter int PIPE_LAT   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_src_valid,
  input  logic [7:0] i_src_data,
  output logic       o_src_ready,
  output logic       o_frame_vsync,
  output logic       o_data_in_valid,
  output logic [7:0] o_data_in,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [9:0] o_line_cnt
);

  typedef enum logic [2:0] {IDLE, VSYNC, ACTIVE, HBLANK, FLUSH} state_t;

  localparam logic [9:0] W_LAST  = 10'(DISP_WIDTH - 1);
  localparam logic [9:0] H_LAST  = 10'(DISP_HIGHT - 1);
  localparam logic [7:0] HB_LAST = 8'(HBLANK_LEN - 1);
  localparam logic [7:0] VS_LAST = 8'(VSYNC_LEN - 1);
  localparam logic [7:0] PL_LAST = 8'(PIPE_LAT - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [9:0] r_x, w_x_nxt;
  logic [9:0] r_line, w_line_nxt;
  logic       r_vsync, r_done, w_done_nxt;
  logic       r_dvalid;
  logic [7:0] r_data;
  logic       w_hs;

  assign w_hs = i_src_valid && (r_state == ACTIVE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_line  <= '0;
      r_vsync <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_line  <= w_line_nxt;
      r_vsync <= (w_state_nxt == VSYNC);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_line_nxt  = r_line;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = VSYNC;
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_line_nxt  = '0;
        end
      end
      VSYNC: begin
        if (r_cnt == VS_LAST) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ACTIVE: begin
        if (w_hs) begin
          if (r_x == W_LAST) begin
            w_x_nxt   = '0;
            w_cnt_nxt = '0;
            if (r_line == H_LAST) begin
              w_state_nxt = FLUSH;
            end else begin
              w_line_nxt  = r_line + 10'd1;
              w_state_nxt = HBLANK;
            end
          end else begin
            w_x_nxt = r_x + 10'd1;
          end
        end
      end
      HBLANK: begin
        if (r_cnt == HB_LAST) begin
          w_state_nxt = ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      FLUSH: begin
        if (r_cnt == PL_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort overrides everything; the pixel path below still honours a handshake this cycle.
    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_x_nxt     = '0;
      w_line_nxt  = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dvalid <= 1'b0;
      r_data   <= '0;
    end else begin
      r_dvalid <= w_hs;
      if (w_hs) r_data <= i_src_data;
    end
  end

  assign o_src_ready     = (r_state == ACTIVE);
  assign o_busy          = (r_state != IDLE);
  assign o_frame_vsync   = r_vsync;
  assign o_frame_done    = r_done;
  assign o_data_in_valid = r_dvalid;
  assign o_data_in       = r_data;
  assign o_line_cnt      = r_line;

endmodule

// File: tb/tb_bayer_frame_sequencer.sv
// Bench for bayer_frame_sequencer (4x3 frame): a per-frame schedule model built from
// the sequencing rules, a table of frame scenarios, and hand-written reset/idle sequences.
module tb_bayer_frame_sequencer;
  localparam int W = 4, H = 3, HB = 2, VS = 2, PL = 4;
  localparam int MAXC = 320;
  localparam int PI = 0, PV = 1, PA = 2, PH = 3, PF = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort, src_valid;
  logic [7:0] src_data;
  logic       src_ready, frame_vsync, data_in_valid, busy, frame_done;
  logic [7:0] data_in;
  logic [9:0] line_cnt;

  bayer_frame_sequencer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .HBLANK_LEN(HB),
                          .VSYNC_LEN(VS), .PIPE_LAT(PL)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_src_valid(src_valid), .i_src_data(src_data), .o_src_ready(src_ready),
    .o_frame_vsync(frame_vsync), .o_data_in_valid(data_in_valid), .o_data_in(data_in),
    .o_busy(busy), .o_frame_done(frame_done), .o_line_cnt(line_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int vmode;       // 0 valid always, 1 toggling, 2 random
    int dmode;       // 0 sequential pixel values, 1 random
    int abort_hs;    // abort in the cycle of this handshake number, 0 = none
    bit spam;        // assert start at random while busy
    int exp_pulses;
    int exp_done;
  } vec_t;

  vec_t tbl [7];
  int   tests = 0, fails = 0;
  int   prev_line = 0;
  int   prev_data = 0;

  bit         v_a  [MAXC];
  logic [7:0] d_a  [MAXC];
  bit         st_a [MAXC];
  bit         ab_a [MAXC];
  int         ph_a [MAXC];
  int         ln_a [MAXC];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " src_ready"}, int'(src_ready), 0);
    chk({tag, " vsync"}, int'(frame_vsync), 0);
    chk({tag, " dvalid"}, int'(data_in_valid), 0);
    chk({tag, " data"}, int'(data_in), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(frame_done), 0);
    chk({tag, " line"}, int'(line_cnt), 0);
  endtask

  // Expected schedule of one frame: phase and line index per cycle, cycle 0 = start cycle.
  task automatic build_model(input vec_t e, output int len, output int done_at);
    int p, hs, l, px, abort_at;
    for (int k = 0; k < MAXC; k++) begin
      case (e.vmode)
        0:       v_a[k] = 1'b1;
        1:       v_a[k] = (k % 2 == 1);
        default: v_a[k] = ($urandom_range(0, 3) != 0);
      endcase
      if (k >= 200) v_a[k] = 1'b1;
      d_a[k]  = (e.dmode == 0) ? 8'(k - (VS + 1)) : 8'($urandom_range(0, 255));
      st_a[k] = 1'b0;
      ab_a[k] = 1'b0;
      ph_a[k] = PI;
      ln_a[k] = 0;
    end
    p = 0;
    ln_a[0] = prev_line;
    for (int i = 0; i < VS; i++) begin
      p++;
      ph_a[p] = PV;
    end
    p++;
    hs = 0; l = 0; abort_at = -1;
    while (l < H && abort_at < 0) begin
      px = 0;
      while (px < W && abort_at < 0) begin
        ph_a[p] = PA;
        ln_a[p] = l;
        if (v_a[p]) begin
          hs++;
          px++;
          if (hs == e.abort_hs) abort_at = p;
        end
        p++;
      end
      if (abort_at < 0) begin
        if (l < H - 1) begin
          for (int i = 0; i < HB; i++) begin ph_a[p] = PH; ln_a[p] = l + 1; p++; end
        end else begin
          for (int i = 0; i < PL; i++) begin ph_a[p] = PF; ln_a[p] = H - 1; p++; end
        end
      end
      l++;
    end
    if (abort_at >= 0) begin
      ab_a[abort_at] = 1'b1;
      p = abort_at + 1;
      done_at = -1;
      for (int i = 0; i < 3; i++) begin ph_a[p + i] = PI; ln_a[p + i] = 0; end
    end else begin
      done_at = p;
      for (int i = 0; i < 3; i++) begin ph_a[p + i] = PI; ln_a[p + i] = H - 1; end
    end
    len = p + 2;
    st_a[0] = 1'b1;
    for (int k = 1; k <= len; k++)
      st_a[k] = e.spam && (ph_a[k] != PI) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_frame(input vec_t e, input int idx);
    int len, done_at, dexp, pulses, dones, edges;
    bit exp_dv, last_vs;
    string tag;
    tag = $sformatf("frame%0d", idx);
    build_model(e, len, done_at);
    dexp = prev_data; pulses = 0; dones = 0; edges = 0; last_vs = 1'b0;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      start = st_a[k]; abort = ab_a[k]; src_valid = v_a[k]; src_data = d_a[k];
      #1;
      exp_dv = (k > 0) && (ph_a[k-1] == PA) && v_a[k-1];
      if (exp_dv) dexp = int'(d_a[k-1]);
      chk({tag, " src_ready"}, int'(src_ready), int'(ph_a[k] == PA));
      chk({tag, " busy"}, int'(busy), int'(ph_a[k] != PI));
      chk({tag, " vsync"}, int'(frame_vsync), int'(ph_a[k] == PV));
      chk({tag, " dvalid"}, int'(data_in_valid), int'(exp_dv));
      chk({tag, " data"}, int'(data_in), dexp);
      chk({tag, " done"}, int'(frame_done), int'(k == done_at));
      chk({tag, " line"}, int'(line_cnt), ln_a[k]);
      pulses += int'(data_in_valid);
      dones  += int'(frame_done);
      if (frame_vsync && !last_vs) edges++;
      last_vs = frame_vsync;
    end
    start = 0; abort = 0; src_valid = 0;
    chk({tag, " pulse total"}, pulses, e.exp_pulses);
    chk({tag, " done total"}, dones, e.exp_done);
    chk({tag, " vsync edges"}, edges, 1);
    prev_line = ln_a[len];
    prev_data = dexp;
  endtask

  initial begin
    tbl[0] = '{vmode: 0, dmode: 0, abort_hs: 0,  spam: 0, exp_pulses: 12, exp_done: 1};
    tbl[1] = '{vmode: 1, dmode: 0, abort_hs: 0,  spam: 0, exp_pulses: 12, exp_done: 1};
    tbl[2] = '{vmode: 2, dmode: 1, abort_hs: 0,  spam: 1, exp_pulses: 12, exp_done: 1};
    tbl[3] = '{vmode: 0, dmode: 1, abort_hs: 6,  spam: 0, exp_pulses: 6,  exp_done: 0};
    tbl[4] = '{vmode: 2, dmode: 1, abort_hs: 0,  spam: 1, exp_pulses: 12, exp_done: 1};
    tbl[5] = '{vmode: 2, dmode: 1, abort_hs: 1,  spam: 1, exp_pulses: 1,  exp_done: 0};
    tbl[6] = '{vmode: 2, dmode: 1, abort_hs: 12, spam: 0, exp_pulses: 12, exp_done: 0};

    rst = 1; start = 0; abort = 0; src_valid = 0; src_data = 0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 0;

    for (int i = 0; i < 4; i++) run_frame(tbl[i], i);

    // start together with abort in IDLE must not launch a frame
    @(negedge clk); start = 1; abort = 1; src_valid = 1;
    #1 chk("idle start+abort busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 0; abort = 0;
      #1 chk("idle start+abort busy", int'(busy), 0);
      chk("idle start+abort vsync", int'(frame_vsync), 0);
      chk("idle start+abort line", int'(line_cnt), prev_line);
    end
    src_valid = 0;

    // async reset while in the first horizontal blank
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      start = (k == 0); src_valid = 1; src_data = 8'(8'hA0 + k);
    end
    #1 chk("hblank busy before rst", int'(busy), 1);
    chk("hblank line before rst", int'(line_cnt), 1);
    rst = 1;
    #1 chk_all_zero("async rst");
    @(negedge clk); start = 0; src_valid = 0;
    #1 chk_all_zero("rst held");
    rst = 0;
    prev_line = 0; prev_data = 0;

    for (int i = 4; i < 7; i++) run_frame(tbl[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bayer_frame_sequencer.md
BAYER_FRAME_SEQUENCER -- requirements
Module: bayer_frame_sequencer

Interface
REQ-001 Parameter DISP_WIDTH, default 402, pixels per padded line; legal range 2..1023.
REQ-002 Parameter DISP_HIGHT, default 402, lines per padded frame; legal range 2..1023.
REQ-003 Parameter HBLANK_LEN, default 16, idle cycles between lines; legal range 1..255.
REQ-004 Parameter VSYNC_LEN, default 4, cycles frame_vsync is held high; legal range 1..255.
REQ-005 Parameter PIPE_LAT, default 4, drain cycles after the last pixel before frame_done; legal range 1..255.
REQ-006 clk  input  1  sole clock; all logic is on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to sequence one frame.
REQ-009 abort  input  1  synchronous cancel of the frame in progress.
REQ-010 src_valid  input  1  source pixel available.
REQ-011 src_data  input  8  source Bayer pixel.
REQ-012 src_ready  output  1  sequencer accepts a pixel this cycle.
REQ-013 frame_vsync  output  1  frame-start strobe to the demosaic datapath.
REQ-014 data_in_valid  output  1  pixel strobe to the datapath.
REQ-015 data_in  output  8  pixel to the datapath.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_done  output  1  single-cycle pulse on completion of a frame.
REQ-018 line_cnt  output  10  index of the line currently being transferred.

Function
REQ-019 The FSM SHALL have the states IDLE, VSYNC, ACTIVE, HBLANK and FLUSH.
REQ-020 IDLE->VSYNC SHALL occur on start; start in any other state SHALL be ignored.
REQ-021 In VSYNC: frame_vsync high, a cycle counter runs, and the FSM goes to ACTIVE after exactly VSYNC_LEN cycles.
REQ-022 src_ready SHALL equal (state==ACTIVE) combinationally; a handshake SHALL occur when src_valid && src_ready.
REQ-023 On a handshake: data_in<=src_data and data_in_valid<=1 (registered, latency 1); otherwise data_in_valid<=0 and data_in holds its value.
REQ-024 The pixel counter x (10 bit) SHALL increment only on a handshake; src_valid low in ACTIVE stalls without error and changes no counter.
REQ-025 Handshake with x==DISP_WIDTH-1: x<=0; then if line_cnt==DISP_HIGHT-1 go to FLUSH, else line_cnt++ and go to HBLANK.
REQ-026 HBLANK SHALL last exactly HBLANK_LEN cycles with src_ready low, then return to ACTIVE.
REQ-027 FLUSH SHALL last exactly PIPE_LAT cycles; on exit, frame_done SHALL pulse for 1 cycle concurrent with entry to IDLE.
REQ-028 Frame totals SHALL be exactly DISP_WIDTH*DISP_HIGHT data_in_valid pulses.
REQ-029 abort in any non-IDLE state SHALL force IDLE on the next edge, clear x, line_cnt and all cycle counters, and suppress frame_done; a handshake in the abort cycle SHALL still produce its data_in_valid pulse.
REQ-030 abort and start in the same cycle in IDLE: abort SHALL win (remain IDLE).
REQ-031 frame_vsync SHALL be registered and glitch-free, low in all states except VSYNC, so each frame presents exactly one rising edge.
REQ-032 line_cnt SHALL reset to 0 on entry to VSYNC and hold its value in IDLE after a completed frame.
REQ-033 Counters SHALL compare with ==, never wrap past parameter limits, and be sized for the legal parameter range.

Reset
REQ-034 While rst is high: state=IDLE; src_ready=0, frame_vsync=0, data_in_valid=0, data_in=0, busy=0, frame_done=0, line_cnt=0, all internal counters 0.
REQ-035 rst asserted mid-frame SHALL take effect immediately (asynchronously); the first start after release SHALL begin a clean frame.

Verification (W=4, H=3, HBLANK_LEN=2, VSYNC_LEN=2, PIPE_LAT=4)
REQ-036 start pulse, src_valid held 1 -> frame_vsync high for 2 cycles; 3 bursts of 4 data_in_valid pulses separated by 2-cycle gaps; frame_done 4 cycles after the last handshake; exactly 12 pulses in total.
REQ-037 Pixel ordering: src_data = 0,1,...,11 -> data_in shows the same sequence, each value one cycle after its handshake.
REQ-038 src_valid toggling 1/0 during ACTIVE -> still 12 pulses, HBLANK still exactly 2 cycles, line_cnt sequence 0,1,2.
REQ-039 abort after the 6th handshake -> IDLE next cycle, busy=0, no frame_done; a following start produces a full 12-pixel frame with line_cnt starting at 0.
REQ-040 start asserted again during ACTIVE, and start+abort together in IDLE -> both ignored; no second frame_vsync edge.
REQ-041 rst pulsed during HBLANK -> all outputs 0 immediately; the next start yields a normal frame.
